// File: rtl/serial_chunk_adder_pkg.sv
// serial_chunk_adder_pkg: shared FSM state type and sizing helper for the
// chunk-serial adder/subtractor.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling log2, used to size the chunk counter from the chunk count N.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// serial_chunk_adder_if: start/ready/done handshake plus operand and result
// bus of the chunk-serial adder. The overflow signal only exists when
// SERIAL_CHUNK_ADDER_OVF_EN is defined.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             ready;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             done;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  logic             overflow;

  modport master (
    output start, sub, a, b, carry_in,
    input  ready, sum, carry_out, done, overflow
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output ready, sum, carry_out, done, overflow
  );
`else
  modport master (
    output start, sub, a, b, carry_in,
    input  ready, sum, carry_out, done
  );

  modport slave (
    input  start, sub, a, b, carry_in,
    output ready, sum, carry_out, done
  );
`endif
endinterface

// File: rtl/serial_chunk_adder_fa_chunk.sv
// fa_chunk: combinational CHUNK-bit ripple adder built from per-bit
// full-adder equations. c_msb_in (carry into the top bit) is only provided
// when SERIAL_CHUNK_ADDER_OVF_EN is defined, for signed overflow detection.
module fa_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  output logic             c_msb_in,
`endif
  output logic             cout
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign cout = w_c[CHUNK];
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  assign c_msb_in = w_c[CHUNK-1];
`endif

endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds/subtracts two WIDTH-bit operands CHUNK bits per
// clock, LSB chunk first, keeping the inter-chunk carry in a register.
// Optional feature macro: SERIAL_CHUNK_ADDER_OVF_EN adds a registered signed
// overflow flag.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst,
  serial_chunk_adder_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             w_last;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_nxt;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  logic             r_ovf;
  logic             w_c_msb_in;
`endif

  // Final chunk is being processed when the counter reaches N-1.
  assign w_last = (r_cnt == CNT_W'(N - 1));

  fa_chunk #(
    .CHUNK (CHUNK)
  ) u_fa_chunk (
    .x        (r_a[CHUNK-1:0]),
    .y        (r_b[CHUNK-1:0]),
    .cin      (r_carry),
    .s        (w_s),
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
    .c_msb_in (w_c_msb_in),
`endif
    .cout     (w_cout)
  );

  // New chunk result enters from the MSB side; after N shifts chunk 0 sits
  // at the bottom of the result.
  if (CHUNK == WIDTH) begin : g_sum_full
    assign w_sum_nxt = w_s;
  end else begin : g_sum_shift
    assign w_sum_nxt = {w_s, r_sum[WIDTH-1:CHUNK]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: accept in IDLE, run N chunks, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then shift one chunk per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ? 1'b1 : bus.carry_in;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_nxt;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_cout <= w_cout;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
            r_ovf  <= w_c_msb_in ^ w_cout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready     = (r_state == IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;
`ifdef SERIAL_CHUNK_ADDER_OVF_EN
  assign bus.overflow  = r_ovf;
`endif

endmodule
